// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART/ALU glue stage: state encoding,
// ALU opcode values and default widths.
package uart_alu_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_NOR = 6'h27;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_e;

   function automatic logic is_busy(input state_e s);
      return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
   endfunction

endpackage

// File: rtl/uart_alu_intf_if.sv
// Bundle of receiver, ALU and transmitter signals seen by uart_alu_intf.
// The slave modport is the glue stage; master is its environment.
interface uart_alu_intf_if
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_OP   = NB_OP_DEF
);
   logic               rx_done_tick;
   logic [NB_DATA-1:0] rx_data;
   logic [NB_DATA-1:0] alu_result;
   logic               tx_done_tick;
   logic [NB_DATA-1:0] alu_a;
   logic [NB_DATA-1:0] alu_b;
   logic [NB_OP-1:0]   alu_op;
   logic               tx_start;
   logic [NB_DATA-1:0] tx_data;
   logic               busy;
   logic               overrun;
   logic               timeout;

   modport slave (
      input  rx_done_tick, rx_data, alu_result, tx_done_tick,
      output alu_a, alu_b, alu_op, tx_start, tx_data, busy, overrun, timeout
   );

   modport master (
      output rx_done_tick, rx_data, alu_result, tx_done_tick,
      input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, overrun, timeout
   );
endinterface

// File: rtl/uart_alu_intf_frame_timer.sv
// Inter-byte timeout counter; expire is asserted while enabled and the count
// has reached TIMEOUT_CYCLES-1.
module frame_timer #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)       count_d = '0;
      else if (enable) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign expire = enable && (count_q == LAST);
endmodule

// File: rtl/uart_alu_intf.sv
// Three-byte frame assembler between UART RX, a combinational ALU and UART TX.
// Optional inter-byte timeout enabled with macro UART_ALU_INTF_TIMEOUT_EN.
module uart_alu_intf
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA        = NB_DATA_DEF,
   parameter int NB_OP          = NB_OP_DEF,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic            clk,
   input  logic            reset,
   uart_alu_intf_if.slave  bus
);
   state_e             state_q, state_d;
   logic [NB_DATA-1:0] alu_a_q, alu_a_d;
   logic [NB_DATA-1:0] alu_b_q, alu_b_d;
   logic [NB_OP-1:0]   alu_op_q, alu_op_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;
   logic               timeout_q, timeout_d;
   logic               accept;
   logic               expire;

   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      overrun_d  = 1'b0;
      timeout_d  = 1'b0;
      accept     = 1'b0;
      case (state_q)
         ST_WAIT_A: if (bus.rx_done_tick) begin
            alu_a_d = bus.rx_data;
            accept  = 1'b1;
            state_d = ST_WAIT_B;
         end
         // A byte in the expiry cycle takes priority over the timeout.
         ST_WAIT_B: if (bus.rx_done_tick) begin
            alu_b_d = bus.rx_data;
            accept  = 1'b1;
            state_d = ST_WAIT_OP;
         end else if (expire) begin
            timeout_d = 1'b1;
            state_d   = ST_WAIT_A;
         end
         ST_WAIT_OP: if (bus.rx_done_tick) begin
            alu_op_d = bus.rx_data[NB_OP-1:0];
            accept   = 1'b1;
            state_d  = ST_EXEC;
         end else if (expire) begin
            timeout_d = 1'b1;
            state_d   = ST_WAIT_A;
         end
         // tx_start is registered, so it is raised on the way into SEND.
         ST_EXEC: begin
            tx_data_d  = bus.alu_result;
            tx_start_d = 1'b1;
            state_d    = ST_SEND;
         end
         ST_SEND:    state_d = ST_WAIT_TX;
         ST_WAIT_TX: if (bus.tx_done_tick) state_d = ST_WAIT_A;
         default:    state_d = ST_WAIT_A;
      endcase
      if (is_busy(state_q) && bus.rx_done_tick) overrun_d = 1'b1;
      busy_d = is_busy(state_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_WAIT_A;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
         timeout_q  <= timeout_d;
      end
   end

`ifdef UART_ALU_INTF_TIMEOUT_EN
   frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept || timeout_d),
      .enable ((state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP)),
      .expire (expire)
   );
`else
   assign expire = 1'b0;
`endif

   assign bus.alu_a    = alu_a_q;
   assign bus.alu_b    = alu_b_q;
   assign bus.alu_op   = alu_op_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_start = tx_start_q;
   assign bus.busy     = busy_q;
   assign bus.overrun  = overrun_q;
   assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed bench for uart_alu_intf with a small behavioural ALU on alu_result.
module tb_uart_alu_intf;
   import uart_alu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   int   tcount;
   int   tpos;

   always #5 clk = ~clk;

   uart_alu_intf_if #(.NB_DATA(8), .NB_OP(6)) bus ();

   uart_alu_intf #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SRA:  return 8'($signed(a) >>> b);
         OP_SRL:  return a >> b;
         OP_NOR:  return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   always_comb bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_done_tick = 1'b1;
      bus.rx_data      = b;
      step();
      bus.rx_done_tick = 1'b0;
   endtask

   task automatic tx_done();
      bus.tx_done_tick = 1'b1;
      step();
      bus.tx_done_tick = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_alu_a"},    32'(bus.alu_a),    32'h0);
      chk({tag, "_alu_b"},    32'(bus.alu_b),    32'h0);
      chk({tag, "_alu_op"},   32'(bus.alu_op),   32'h0);
      chk({tag, "_tx_data"},  32'(bus.tx_data),  32'h0);
      chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'h0);
      chk({tag, "_busy"},     32'(bus.busy),     32'h0);
      chk({tag, "_overrun"},  32'(bus.overrun),  32'h0);
      chk({tag, "_timeout"},  32'(bus.timeout),  32'h0);
   endtask

   initial begin
      reset            = 1'b1;
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'h00;
      bus.tx_done_tick = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();

      // Stray tx_done in WAIT_A, then a back-to-back basic frame.
      tx_done();
      chk("stray_txdone_busy", 32'(bus.busy), 32'h0);
      send_byte(8'h05);
      chk("basic_a", 32'(bus.alu_a), 32'h05);
      chk("basic_a_busy", 32'(bus.busy), 32'h0);
      send_byte(8'h03);
      chk("basic_b", 32'(bus.alu_b), 32'h03);
      send_byte(8'h20);
      chk("basic_op", 32'(bus.alu_op), 32'h20);
      chk("basic_exec_busy", 32'(bus.busy), 32'h1);
      chk("basic_t1_start", 32'(bus.tx_start), 32'h0);
      step();
      chk("basic_t2_start", 32'(bus.tx_start), 32'h1);
      chk("basic_t2_data", 32'(bus.tx_data), 32'h08);
      step();
      chk("basic_t3_start", 32'(bus.tx_start), 32'h0);
      chk("basic_t3_busy", 32'(bus.busy), 32'h1);

      // Overrun during WAIT_TX.
      send_byte(8'h77);
      chk("ovr_pulse", 32'(bus.overrun), 32'h1);
      chk("ovr_busy", 32'(bus.busy), 32'h1);
      chk("ovr_a_hold", 32'(bus.alu_a), 32'h05);
      step();
      chk("ovr_pulse_end", 32'(bus.overrun), 32'h0);
      chk("ovr_no_start", 32'(bus.tx_start), 32'h0);

      // Byte coincident with tx_done is dropped; next cycle accepts A.
      bus.tx_done_tick = 1'b1;
      bus.rx_done_tick = 1'b1;
      bus.rx_data      = 8'h99;
      step();
      bus.tx_done_tick = 1'b0;
      bus.rx_done_tick = 1'b0;
      chk("u_drop_overrun", 32'(bus.overrun), 32'h1);
      chk("u_idle_busy", 32'(bus.busy), 32'h0);
      chk("u_drop_a_hold", 32'(bus.alu_a), 32'h05);
      send_byte(8'h10);
      chk("u1_accept_a", 32'(bus.alu_a), 32'h10);
      step();
      send_byte(8'h01);
      send_byte(8'hE2);
      chk("mask_op", 32'(bus.alu_op), 32'h22);
      chk("mask_b", 32'(bus.alu_b), 32'h01);
      step();
      chk("sub_start", 32'(bus.tx_start), 32'h1);
      chk("sub_data", 32'(bus.tx_data), 32'h0F);
      step();
      tx_done();
      chk("sub_done_busy", 32'(bus.busy), 32'h0);

      // Reset mid-frame.
      send_byte(8'h44);
      chk("rst_pre_a", 32'(bus.alu_a), 32'h44);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_all_zero("midrst");
      send_byte(8'h02);
      send_byte(8'h02);
      send_byte(8'h24);
      step();
      chk("and_start", 32'(bus.tx_start), 32'h1);
      chk("and_data", 32'(bus.tx_data), 32'h02);
      step();
      tx_done();

      // Idle gap after operand A.
      send_byte(8'h33);
      tcount = 0;
      tpos   = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.timeout) begin
            tcount++;
            tpos = i;
         end
      end
      chk("gap_busy", 32'(bus.busy), 32'h0);
`ifdef UART_ALU_INTF_TIMEOUT_EN
      chk("tmo_count", 32'(tcount), 32'd1);
      chk("tmo_pos", 32'(tpos), 32'd15);
      send_byte(8'h06);
      chk("tmo_fresh_a", 32'(bus.alu_a), 32'h06);
      send_byte(8'h07);
      send_byte(8'h20);
      step();
      chk("gap_start", 32'(bus.tx_start), 32'h1);
      chk("gap_data", 32'(bus.tx_data), 32'h0D);
`else
      chk("notmo_count", 32'(tcount), 32'd0);
      send_byte(8'h07);
      send_byte(8'h20);
      step();
      chk("gap_start", 32'(bus.tx_start), 32'h1);
      chk("gap_data", 32'(bus.tx_data), 32'h3A);
`endif
      step();
      tx_done();

      // Arithmetic shift right.
      send_byte(8'h80);
      send_byte(8'h02);
      send_byte(8'h03);
      step();
      chk("sra_start", 32'(bus.tx_start), 32'h1);
      chk("sra_data", 32'(bus.tx_data), 32'hE0);
      step();
      tx_done();
      chk("end_busy", 32'(bus.busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
